// File: rtl/morse_symbol_sequencer_pkg.sv
// morse_pkg: shared types and constants for the Morse key front-end.
//   state_e    - sequencer FSM states
//   LEN_W      - width of the symbol-count field in the packed letter
//   CODE_W     - width of the symbol field in the packed letter
//   pack_code  - builds the {length, code} byte the decoder consumes
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    EMIT  = 2'd3
  } state_e;

  localparam int LEN_W       = 3;
  localparam int CODE_W      = 5;
  localparam int MAX_SYMBOLS = 5;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  // Length goes in the top bits so the decoder can find where the
  // right-aligned symbol field starts.
  function automatic logic [LEN_W+CODE_W-1:0] pack_code(
    input logic [LEN_W-1:0]  len,
    input logic [CODE_W-1:0] code
  );
    return {len, code};
  endfunction

endpackage

// File: rtl/morse_symbol_sequencer_timer.sv
// morse_timer: saturating up-counter used to time key presses and gaps.
//   clk, reset_n - clock, asynchronous active-low reset
//   clear_i      - force count to 0 (highest priority)
//   start_i      - load count with 1 (the current cycle is the first one)
//   inc_i        - increment, saturating at LIMIT
//   hit_o        - the count after this cycle is at (or held at) LIMIT
module morse_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic start_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear beats start beats increment; never counts past LIMIT.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (start_i) begin
      count_d = W'(1);
    end else if (inc_i && (count_q < LIMIT_V)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Looking at the next value lets the gap timer flag expiry on the very
  // cycle of the last low sample, while a held press count still reads
  // correctly on the release cycle.
  assign hit_o = (count_d >= LIMIT_V);

endmodule

// File: rtl/morse_symbol_sequencer.sv
// morse_symbol_sequencer: times a synchronised Morse key, classifies each
// press as dot/dash, and hands a packed {length, code} letter to the decoder.
//   clk, reset_n - clock, asynchronous active-low reset
//   key          - 1 = key pressed (already synchronised)
//   clear        - synchronous abort of the current letter, clears overflow
//   code_out     - {length[2:0], code[4:0]}, valid while code_valid
//   code_valid   - a completed letter is offered
//   code_ready   - consumer accepts the letter
//   dot_t        - one-cycle pulse when a press is classified as a dot
//   wait_t       - one-cycle pulse when the letter gap expires
//   overflow     - sticky: a letter had more than MAX_SYMBOLS symbols
//   busy         - sequencer is not idle
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int DOT_TIME  = 25_000_000,
  parameter int WAIT_TIME = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key,
  input  logic       clear,
  output logic [7:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       dot_t,
  output logic       wait_t,
  output logic       overflow,
  output logic       busy
);

  localparam int MAX_TIME = (DOT_TIME > WAIT_TIME) ? DOT_TIME : WAIT_TIME;
  localparam int CNT_W    = $clog2(MAX_TIME) + 1;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                ovf_q, ovf_d;
  logic                ovf_letter_q, ovf_letter_d;

  logic press_start, press_inc, press_hit;
  logic gap_start, gap_inc, gap_clr, gap_hit;
  logic sym;

  // Timer controls depend only on registered state and inputs, never on the
  // timer flags, so there is no combinational path back into the counters.
  assign press_start = !clear && key &&
                       ((state_q == IDLE) || (state_q == GAP) ||
                        ((state_q == EMIT) && code_ready));
  assign press_inc   = !clear && (state_q == PRESS) && key;
  assign gap_start   = !clear && (state_q == PRESS) && !key;
  assign gap_inc     = !clear && (state_q == GAP) && !key;
  assign gap_clr     = clear || ((state_q == GAP) && key);

  morse_timer #(.W(CNT_W), .LIMIT(DOT_TIME)) u_press_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clear),
    .start_i (press_start),
    .inc_i   (press_inc),
    .hit_o   (press_hit)
  );

  morse_timer #(.W(CNT_W), .LIMIT(WAIT_TIME)) u_gap_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (gap_clr),
    .start_i (gap_start),
    .inc_i   (gap_inc),
    .hit_o   (gap_hit)
  );

  // On the release cycle the press counter is held, so its flag says
  // whether the press lasted at least DOT_TIME cycles.
  assign sym = press_hit ? DASH : DOT;

  // Next-state and symbol accumulation; clear overrides everything.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    code_d       = code_q;
    ovf_d        = ovf_q;
    ovf_letter_d = ovf_letter_q;
    dot_t        = 1'b0;
    wait_t       = 1'b0;
    if (clear) begin
      state_d      = IDLE;
      len_d        = '0;
      code_d       = '0;
      ovf_d        = 1'b0;
      ovf_letter_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key) state_d = PRESS;
        end
        PRESS: begin
          if (!key) begin
            if (len_q < LEN_W'(MAX_SYMBOLS)) begin
              code_d = {code_q[CODE_W-2:0], sym};
              len_d  = len_q + LEN_W'(1);
            end else begin
              ovf_d        = 1'b1;
              ovf_letter_d = 1'b1;
            end
            dot_t   = (sym == DOT);
            state_d = GAP;
          end
        end
        GAP: begin
          if (key) begin
            state_d = PRESS;
          end else if (gap_hit) begin
            wait_t = 1'b1;
            if (ovf_letter_q) begin
              len_d        = '0;
              code_d       = '0;
              ovf_letter_d = 1'b0;
              state_d      = IDLE;
            end else begin
              state_d = EMIT;
            end
          end
        end
        EMIT: begin
          if (code_ready) begin
            len_d   = '0;
            code_d  = '0;
            state_d = key ? PRESS : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and letter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      code_q       <= '0;
      ovf_q        <= 1'b0;
      ovf_letter_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      code_q       <= code_d;
      ovf_q        <= ovf_d;
      ovf_letter_q <= ovf_letter_d;
    end
  end

  // len/code only change on the handshake, so code_out is stable under
  // backpressure; it reads 0 whenever no letter is offered.
  assign code_valid = (state_q == EMIT);
  assign code_out   = code_valid ? pack_code(len_q, code_q) : 8'h00;
  assign overflow   = ovf_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Testbench for morse_symbol_sequencer with DOT_TIME=2, WAIT_TIME=5.
// Letters are described as lists of press lengths; the expected byte,
// dot count and overflow are worked out arithmetically from those lists.
module tb_morse_symbol_sequencer;

  localparam int DOT_TIME  = 2;
  localparam int WAIT_TIME = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key = 1'b0;
  logic       clear = 1'b0;
  logic       code_ready = 1'b1;
  logic [7:0] code_out;
  logic       code_valid;
  logic       dot_t;
  logic       wait_t;
  logic       overflow;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cycleNo = 0;
  int dotSeen = 0;
  int waitSeen = 0;
  int lastWaitCycle = -1;
  int lastHsCycle = -1;
  logic [7:0] hsQueue[$];
  int pressLen[$];
  logic expOverflow = 1'b0;

  morse_symbol_sequencer #(.DOT_TIME(DOT_TIME), .WAIT_TIME(WAIT_TIME)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key        (key),
    .clear      (clear),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .dot_t      (dot_t),
    .wait_t     (wait_t),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Event recorder: pulses and accepted letters, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (dot_t) dotSeen++;
      if (wait_t) begin
        waitSeen++;
        lastWaitCycle = cycleNo;
      end
      if (code_valid && code_ready) begin
        hsQueue.push_back(code_out);
        lastHsCycle = cycleNo;
      end
    end
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Hold key at k for n cycles; returns 1 time unit after a rising edge.
  task automatic applyStimulus(input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      key = k;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearCounters();
    dotSeen  = 0;
    waitSeen = 0;
    hsQueue.delete();
  endtask

  // Plays the letter in pressLen with random intra-letter gaps and checks it.
  task automatic playLetter();
    int n;
    int len;
    int code;
    int dots;
    bit ovf;
    bit sym;
    logic [7:0] expByte;
    n = pressLen.size();
    len = 0;
    code = 0;
    dots = 0;
    ovf = 1'b0;
    clearCounters();
    for (int i = 0; i < n; i++) begin
      sym = (pressLen[i] >= DOT_TIME);
      if (!sym) dots++;
      if (len < 5) begin
        code = code * 2 + int'(sym);
        len++;
      end else begin
        ovf = 1'b1;
      end
      applyStimulus(1'b1, pressLen[i]);
      if (i != n - 1) applyStimulus(1'b0, int'($urandom_range(WAIT_TIME - 1, 1)));
    end
    applyStimulus(1'b0, WAIT_TIME + 1);
    expOverflow = expOverflow | ovf;
    expByte = 8'(len * 32 + code);
    checkOutput("dotCount", dotSeen, dots);
    checkOutput("waitCount", waitSeen, 1);
    checkOutput("emitCount", hsQueue.size(), ovf ? 0 : 1);
    if (!ovf && hsQueue.size() == 1) begin
      checkOutput("codeOut", hsQueue[0], expByte);
      checkOutput("latency", lastHsCycle - lastWaitCycle, 1);
    end
    checkOutput("overflow", overflow, expOverflow);
    checkOutput("busyAfter", busy, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_codeOut"}, code_out, 0);
    checkOutput({tag, "_valid"}, code_valid, 0);
    checkOutput({tag, "_dot"}, dot_t, 0);
    checkOutput({tag, "_wait"}, wait_t, 0);
    checkOutput({tag, "_ovf"}, overflow, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    // Reset held for two cycles, then an idle stretch.
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkAllZero("postReset");
    clearCounters();
    applyStimulus(1'b0, 20);
    checkOutput("idleEmit", hsQueue.size(), 0);
    checkOutput("idleWait", waitSeen, 0);

    // 'E' and 'W'.
    pressLen = '{1};
    playLetter();
    pressLen = '{1, 3, 3};
    playLetter();

    // 'K' under backpressure with key activity during EMIT.
    clearCounters();
    code_ready = 1'b0;
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, WAIT_TIME);
    for (int i = 0; i < 10; i++) begin
      key = (i % 2) == 0;
      @(negedge clk);
      checkOutput("bpValid", code_valid, 1);
      checkOutput("bpCode", code_out, 8'b011_00101);
      checkOutput("bpDot", dot_t, 0);
      @(posedge clk);
      #1;
    end
    key = 1'b0;
    code_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpHsValid", code_valid, 1);
    @(posedge clk);
    #1;
    checkOutput("bpDropValid", code_valid, 0);
    checkOutput("bpBusy", busy, 0);
    checkOutput("bpHsCount", hsQueue.size(), 1);
    checkOutput("bpDotCount", dotSeen, 1);

    // Six symbols overflow; the following 'E' still emits; clear drops flag.
    pressLen = '{1, 1, 1, 1, 1, 1};
    playLetter();
    pressLen = '{1};
    playLetter();
    clear = 1'b1;
    applyStimulus(1'b0, 1);
    clear = 1'b0;
    expOverflow = 1'b0;
    checkOutput("clearOvf", overflow, 0);

    // Randomized letters, some of them overflowing.
    for (int l = 0; l < 15; l++) begin
      int n;
      n = int'($urandom_range(6, 1));
      pressLen.delete();
      for (int s = 0; s < n; s++) pressLen.push_back(int'($urandom_range(4, 1)));
      playLetter();
    end
    clear = 1'b1;
    applyStimulus(1'b0, 1);
    clear = 1'b0;
    expOverflow = 1'b0;

    // Asynchronous reset in the middle of a press, then 'T'.
    applyStimulus(1'b1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("midReset");
    key = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clearCounters();
    applyStimulus(1'b0, 10);
    checkOutput("noSpuriousValid", hsQueue.size(), 0);
    pressLen = '{2};
    playLetter();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_symbol_sequencer.md
Name: morse_symbol_sequencer

Overview:
Front-end controller for the Morse decoder datapath. It times a raw key input, classifies each press as dot or dash, and accumulates up to 5 symbols. On a letter gap it emits the packed {length[2:0], code[4:0]} byte that the decoder consumes on its `inital` input, using a valid/ready handshake. The decoder then runs in direct-input mode (MODE=0) with no software bit-banging through the Avalon register.

Parameters:
- DOT_TIME, 25_000_000: press of at least this many cycles is a dash; shorter is a dot.
- WAIT_TIME, 50_000_000: consecutive key-low cycles after a symbol that end a letter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- key  in  1  Morse key; 1 = pressed; already synchronised to clk
- clear  in  1  synchronous abort; discards the current letter and clears overflow
- code_out  out  8  {length[2:0], code[4:0]}; code right-aligned, first symbol most significant; dot=0, dash=1
- code_valid  out  1  code_out holds a completed letter
- code_ready  in  1  consumer accepts the letter when code_valid && code_ready
- dot_t  out  1  one-cycle pulse when a press is classified as a dot
- wait_t  out  1  one-cycle pulse when the letter-gap timer expires
- overflow  out  1  sticky; a 6th symbol was entered in one letter
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; press_cnt=0, gap_cnt=0, len=0, code=0.
  - All outputs are 0.
- States: IDLE, PRESS, GAP, EMIT.
- IDLE, on key=1: go to PRESS with press_cnt=1.
- PRESS, while key=1: press_cnt increments, saturating at DOT_TIME.
- PRESS, on the first key=0 cycle:
  - bit = (press_cnt >= DOT_TIME).
  - If len<5: code <= {code[3:0], bit}, len <= len+1.
  - Else: overflow <= 1; code and len are unchanged.
  - dot_t pulses that cycle if bit=0.
  - Go to GAP with gap_cnt=1.
- GAP:
  - key=1: go to PRESS with press_cnt=1; gap_cnt cleared.
  - key=0: gap_cnt increments.
  - When gap_cnt reaches WAIT_TIME: wait_t pulses for one cycle.
    - If overflow was set during this letter: drop the letter (len=0, code=0) and return to IDLE, no emit.
    - Otherwise go to EMIT.
- EMIT:
  - code_valid=1; code_out={len, code} is registered and held stable while code_ready=0.
  - Key activity is ignored (no timing, no pulses).
  - On code_valid && code_ready:
    - Clear len and code; code_valid drops the next cycle.
    - If key=1 that cycle, go to PRESS with press_cnt=1; else go to IDLE.
- Latency: code_valid rises on the cycle after the WAIT_TIME-th consecutive low sample.
- clear=1: highest priority after reset. Next state IDLE; counters, len, code, code_valid and overflow are all cleared. clear during EMIT drops the pending letter.
- Overflow:
  - Stays 1 until clear or reset.
  - Later letters still decode and emit normally unless they themselves overflow. Per-letter tracking uses an internal ovf_letter flag.
- Counter widths: $clog2(max(DOT_TIME, WAIT_TIME))+1 bits.
  - press_cnt saturates at DOT_TIME.
  - gap_cnt never exceeds WAIT_TIME.
- Simultaneous events:
  - key rise on the same cycle gap_cnt would hit WAIT_TIME: the press wins, the letter continues and wait_t does not pulse.
- Mid-operation reset: the partial letter is lost; no spurious code_valid after release.

Decomposition:
- Package morse_pkg:
  - state enum {IDLE, PRESS, GAP, EMIT}.
  - LEN_W=3, CODE_W=5, MAX_SYMBOLS=5.
  - DOT=1'b0, DASH=1'b1.
  - Function pack_code(len, code).
- Sub-module morse_timer: saturating up-counter with start/clear/limit and a terminal-count flag. Instantiated twice: press timing (limit DOT_TIME) and gap timing (limit WAIT_TIME).

Test Plan (DOT_TIME=2, WAIT_TIME=5, code_ready=1 unless stated):
- Reset: hold reset_n=0 for 2 cycles, then release. All outputs are 0 and busy=0. Drive key=0 for 20 cycles → no code_valid.
- 'E': key=1 for 1 cycle, then 0 → dot_t pulses once; wait_t after 5 low cycles; next cycle code_valid=1 for exactly 1 cycle, code_out=8'b001_00000.
- 'W': press 1 cycle, 2 low, press 3 cycles, 2 low, press 3 cycles, 5 low → code_out=8'b011_00011, one dot_t pulse.
- Backpressure: emit 'K' (press 3/1/3, gaps 2) with code_ready=0 for 10 cycles, plus key pulses during EMIT.
  - code_out=8'b011_00101 is held stable and code_valid stays 1; no dot_t.
  - Raise code_ready → single handshake, then IDLE.
- Overflow: six 1-cycle presses with 2-cycle gaps, then 5 low → overflow=1, no code_valid, returns to IDLE. A following 'E' still emits 8'b001_00000 with overflow still 1. Pulse clear → overflow=0.
- Async reset mid-PRESS, then 'T' (press 2 cycles, 5 low):
  - During the reset, all outputs drop immediately.
  - Afterwards 'T' emits code_out=8'b001_00001.
